// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: ALU codes,
// opcode/funct values, FSM state type and datapath mux encodings.
// Optional feature macro: MC_IMM_ALU_EN (immediate ALU ops addi/andi/ori/slti).
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_R_EX   = 4'd6,
    S_R_WB   = 4'd7,
    S_BEQ    = 4'd8,
`ifdef MC_IMM_ALU_EN
    S_JUMP   = 4'd9,
    S_I_EX   = 4'd10,
    S_I_WB   = 4'd11
`else
    S_JUMP   = 4'd9
`endif
  } state_t;

`ifdef MC_IMM_ALU_EN
  // True for the immediate-operand ALU opcodes.
  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  // ALU code for an immediate-operand ALU opcode.
  function automatic logic [2:0] imm_alu_code(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction
`endif

endpackage

// File: rtl/alu_decode.sv
// R-type funct to ALU code decoder; valid flags a supported funct.
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_signal,
  output logic       valid
);

  // Map funct to ALU operation and flag unsupported values.
  always_comb begin
    alu_signal = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FN_ADD:  alu_signal = ALU_ADD;
      FN_SUB:  alu_signal = ALU_SUB;
      FN_AND:  alu_signal = ALU_AND;
      FN_OR:   alu_signal = ALU_OR;
      FN_SLT:  alu_signal = ALU_SLT;
      default: valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// writeback and drives all datapath enables, mux selects and the ALU code.
// Optional feature macro: MC_IMM_ALU_EN adds addi/andi/ori/slti via I_EX/I_WB.
module mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_signal,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state;
  logic [2:0] r_signal;
  logic       r_valid;
  logic       legal;
  logic       pc_write;
  logic       branch;

  alu_decode u_alu_decode (
    .funct      (funct),
    .alu_signal (r_signal),
    .valid      (r_valid)
  );

  // Opcode legality, shared by the DECODE transition and the illegal pulse.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      OP_RTYPE:                   legal = r_valid;
      default: begin
`ifdef MC_IMM_ALU_EN
        legal = is_imm_alu(opcode);
`endif
      end
    endcase
  end

  // State register and transitions; stray encodings recover to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (!legal)                                state <= S_FETCH;
          else if (opcode == OP_LW || opcode == OP_SW) state <= S_MEMADR;
          else if (opcode == OP_RTYPE)               state <= S_R_EX;
          else if (opcode == OP_BEQ)                 state <= S_BEQ;
          else if (opcode == OP_J)                   state <= S_JUMP;
`ifdef MC_IMM_ALU_EN
          else                                       state <= S_I_EX;
`else
          else                                       state <= S_FETCH;
`endif
        end
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_R_EX:   state <= S_R_WB;
`ifdef MC_IMM_ALU_EN
        S_I_EX:   state <= S_I_WB;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; outputs are forced low while reset is held so the
  // FETCH state it parks in cannot touch memory or the PC.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_signal = ALU_AND;
    pc_source  = PCSRC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_read   = 1'b1;
          ir_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          alu_signal = ALU_ADD;
          pc_write   = 1'b1;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_BRANCH;
          alu_signal = ALU_ADD;
          illegal    = !legal;
          instr_done = !legal;
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_signal = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = 1'b1;
        end
        S_R_EX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RT;
          alu_signal = r_signal;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = 1'b1;
          alu_signal = ALU_SUB;
          branch     = 1'b1;
          pc_source  = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
`ifdef MC_IMM_ALU_EN
        S_I_EX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_signal = imm_alu_code(opcode);
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle output vectors compared
// against an instruction-level reference model of the control sequence.
module tb_mc_control;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_signal;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_signal;

  int unsigned errors = 0;
  int unsigned checks = 0;
  ov_t exp_q[$];
  ov_t obs;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_signal(alu_signal), .pc_source(pc_source), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = '{pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_signal, pc_source,
                 instr_done, illegal};

  // R-type funct table: returns 1 with the ALU code when supported.
  function automatic logic rfunct(input logic [5:0] f, output logic [2:0] code);
    code = 3'b000;
    case (f)
      6'd32: begin code = 3'b010; return 1'b1; end
      6'd34: begin code = 3'b110; return 1'b1; end
      6'd36: begin code = 3'b000; return 1'b1; end
      6'd37: begin code = 3'b001; return 1'b1; end
      6'd42: begin code = 3'b111; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: list of per-cycle outputs for one whole instruction.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ov_t v;
    logic [2:0] code;
    logic rok;
    exp_q.delete();
    v = '0; v.mem_read = 1; v.ir_write = 1; v.alu_src_b = 2'b01; v.alu_signal = 3'b010; v.pc_en = 1;
    exp_q.push_back(v);
    v = '0; v.alu_src_b = 2'b11; v.alu_signal = 3'b010;
    rok = rfunct(fn, code);
    if (op == 6'd35 || op == 6'd43) begin
      exp_q.push_back(v);
      v = '0; v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_signal = 3'b010; exp_q.push_back(v);
      if (op == 6'd35) begin
        v = '0; v.mem_read = 1; v.iord = 1; exp_q.push_back(v);
        v = '0; v.reg_write = 1; v.mem_to_reg = 1; v.instr_done = 1; exp_q.push_back(v);
      end else begin
        v = '0; v.mem_write = 1; v.iord = 1; v.instr_done = 1; exp_q.push_back(v);
      end
    end else if (op == 6'd0 && rok) begin
      exp_q.push_back(v);
      v = '0; v.alu_src_a = 1; v.alu_signal = code; exp_q.push_back(v);
      v = '0; v.reg_write = 1; v.reg_dst = 1; v.instr_done = 1; exp_q.push_back(v);
    end else if (op == 6'd4) begin
      exp_q.push_back(v);
      v = '0; v.alu_src_a = 1; v.alu_signal = 3'b110; v.pc_source = 2'b01;
      v.pc_en = z; v.instr_done = 1; exp_q.push_back(v);
    end else if (op == 6'd2) begin
      exp_q.push_back(v);
      v = '0; v.pc_en = 1; v.pc_source = 2'b10; v.instr_done = 1; exp_q.push_back(v);
`ifdef MC_IMM_ALU_EN
    end else if (op == 6'd8 || op == 6'd10 || op == 6'd12 || op == 6'd13) begin
      exp_q.push_back(v);
      v = '0; v.alu_src_a = 1; v.alu_src_b = 2'b10;
      v.alu_signal = (op == 6'd8) ? 3'b010 : (op == 6'd10) ? 3'b111 :
                     (op == 6'd12) ? 3'b000 : 3'b001;
      exp_q.push_back(v);
      v = '0; v.reg_write = 1; v.instr_done = 1; exp_q.push_back(v);
`endif
    end else begin
      v.illegal = 1; v.instr_done = 1; exp_q.push_back(v);
    end
  endfunction

  // Execute one instruction from FETCH, comparing every cycle with the model.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
    build(op, fn, z);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s op=%0d fn=%0d cycle %0d: got %h expected %h", name, op, fn, i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    ov_t zv;
    zv = '0;
    reset = 0; opcode = 6'd35; funct = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== zv) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, zv);
      end
    end
    @(posedge clk); #1;
    reset = 1;
    run_instr("lw_after_reset", 6'd35, 6'd0, 1'b0);
  endtask

  task automatic test_rtype;
    run_instr("r_slt", 6'd0, 6'd42, 1'b0);
    run_instr("r_add", 6'd0, 6'd32, 1'b1);
    run_instr("r_sub", 6'd0, 6'd34, 1'b0);
    run_instr("r_and", 6'd0, 6'd36, 1'b0);
    run_instr("r_or",  6'd0, 6'd37, 1'b0);
  endtask

  task automatic test_branch_jump;
    run_instr("beq_taken", 6'd4, 6'd0, 1'b1);
    run_instr("beq_not_taken", 6'd4, 6'd0, 1'b0);
    run_instr("jump", 6'd2, 6'd0, 1'b0);
  endtask

  task automatic test_illegal;
    run_instr("illegal_op63", 6'd63, 6'd0, 1'b0);
    run_instr("illegal_funct0", 6'd0, 6'd0, 1'b0);
    run_instr("ori", 6'd13, 6'd5, 1'b0);
    run_instr("addi", 6'd8, 6'd0, 1'b0);
    run_instr("sw", 6'd43, 6'd0, 1'b0);
  endtask

  // sw interrupted by reset in MEMWR: mem_write must fall without a clock edge.
  task automatic test_reset_mid;
    ov_t zv;
    zv = '0;
    build(6'd43, 6'd0, 1'b0);
    opcode = 6'd43; funct = 6'd0; zero = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL sw_pre_reset cycle %0d: got %h expected %h", i, obs, exp_q[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #1 reset = 0;
    #1;
    checks++;
    if (obs !== zv) begin
      errors++;
      $display("FAIL async_reset_drop: got %h expected %h", obs, zv);
    end
    @(posedge clk); #1;
    reset = 1;
    run_instr("after_mid_reset", 6'd0, 6'd37, 1'b0);
  endtask

  task automatic test_random;
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'd0, 6'd2, 6'd4, 6'd35, 6'd43, 6'd12, 6'd10, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
      else fn = fns[$urandom_range(0, 4)];
      run_instr("random", op, fn, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
